imem_loader: RTL and testbench

Sequential writer that fills the 512-byte, byte-addressed, big-endian instruction memory before the CPU runs. It accepts 32-bit instruction words over a valid/ready handshake and serializes each word into four byte writes at consecutive addresses. While loading, it holds the program counter in reset through `cpu_hold`, and releases it once the last word has been written.

---
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: fills the byte-addressed, big-endian instruction memory
// one 32-bit word at a time. The CPU is held in reset until a session
// ends with a last-flagged word.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | no session active, CPU held
// S_ACCEPT | waiting for the next word (ready only if room left)
// S_WRITE  | streaming the latched word out, byte bi_q = 0..3
// S_DONE   | session completed, CPU released
// S_ERR    | word offered with memory full, session aborted
module imem_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 8
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [31:0]       in_word_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  word_count_o
);
    // One extra bit so the pointer can sit at DEPTH once memory is full.
    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LIMIT = PTR_W'(DEPTH - 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [1:0]       bi_q, bi_d;
    logic [31:0]      word_q, word_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             room;

    assign room         = (ptr_q <= PTR_LIMIT);
    assign word_count_o = count_q;

    // State and datapath registers, synchronous reset.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            bi_q    <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bi_q    <= bi_d;
            word_q  <= word_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Next-state logic and Moore/handshake outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        bi_d       = bi_q;
        word_d     = word_q;
        last_d     = last_q;
        count_d    = count_q;
        in_ready_o = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        cpu_hold_o = 1'b1;
        done_o     = 1'b0;
        overflow_o = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                done_o     = (state_q == S_DONE);
                cpu_hold_o = (state_q != S_DONE);
                overflow_o = (state_q == S_ERR);
                // Every new session starts from address 0 with a fresh count.
                if (start_i) begin
                    state_d = S_ACCEPT;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            S_ACCEPT: begin
                in_ready_o = room;
                if (in_valid_i) begin
                    if (room) begin
                        word_d  = in_word_i;
                        last_d  = in_last_i;
                        bi_d    = 2'd0;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                mem_we_o   = 1'b1;
                mem_addr_o = ptr_q[ADDR_W-1:0] + ADDR_W'(bi_q);
                // Big-endian: byte 0 of the word is its most significant byte.
                case (bi_q)
                    2'd0:    mem_data_o = word_q[31:24];
                    2'd1:    mem_data_o = word_q[23:16];
                    2'd2:    mem_data_o = word_q[15:8];
                    default: mem_data_o = word_q[7:0];
                endcase
                if (bi_q != 2'd3) begin
                    bi_d = bi_q + 2'd1;
                end else begin
                    ptr_d   = ptr_q + PTR_W'(4);
                    count_d = count_q + CNT_W'(1);
                    state_d = last_q ? S_DONE : S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized word streams checked
// against a queue of expected byte writes built from the memory-layout rules.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 8;

    logic              Clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              start_i    = 1'b0;
    logic              in_valid_i = 1'b0;
    logic [31:0]       in_word_i  = '0;
    logic              in_last_i  = 1'b0;
    logic              in_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_o;
    logic              cpu_hold_o;
    logic              done_o;
    logic              overflow_o;
    logic [CNT_W-1:0]  word_count_o;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .reset(reset), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_word_i(in_word_i), .in_last_i(in_last_i),
        .in_ready_o(in_ready_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .cpu_hold_o(cpu_hold_o), .done_o(done_o),
        .overflow_o(overflow_o), .word_count_o(word_count_o)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] shadow [DEPTH];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_wr_addr = -1;
    int         m_ptr = 0;
    int         m_wc  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // Memory side: every strobed byte must be the next one the model expects.
    always @(negedge Clk) begin
        if (mem_we_o === 1'b1) begin
            shadow[mem_addr_o] = mem_data_o;
            last_wr_addr = int'(mem_addr_o);
            if (exp_q.size() == 0) begin
                check_eq("unexp_we", {31'd0, mem_we_o}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", {23'd0, mem_addr_o}, mon_e.a);
                check_eq("wr_data", {24'd0, mem_data_o}, {24'd0, mon_e.d});
            end
        end
    end

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        m_ptr = 0;
        m_wc  = 0;
    endtask

    // Holds the word valid until accepted; returns with the handshake edge just past.
    task automatic offer(input logic [31:0] w, input logic last, output int hs_cyc);
        wr_t e;
        bit  got;
        got = 1'b0;
        in_word_i  = w;
        in_last_i  = last;
        in_valid_i = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (in_ready_o === 1'b1) got = 1'b1;
            else tick();
        end
        hs_cyc = cyc;
        if (!got) begin
            check_eq("hs_timeout", {31'd0, in_ready_o}, 32'd1);
            in_valid_i = 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                e.a = m_ptr + b;
                e.d = w[31-8*b -: 8];
                exp_q.push_back(e);
            end
            m_ptr += 4;
            m_wc++;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          h0, h1, h2, n;
        logic [31:0] w;
        logic [31:0] words3 [3];

        // Reset state
        tick();
        tick();
        check_eq("rst_cpu_hold", {31'd0, cpu_hold_o}, 32'd1);
        check_eq("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check_eq("rst_mem_we",   {31'd0, mem_we_o}, 32'd0);
        check_eq("rst_mem_addr", {23'd0, mem_addr_o}, 32'd0);
        check_eq("rst_mem_data", {24'd0, mem_data_o}, 32'd0);
        check_eq("rst_wc",       {24'd0, word_count_o}, 32'd0);
        check_eq("rst_done",     {31'd0, done_o}, 32'd0);
        check_eq("rst_ovf",      {31'd0, overflow_o}, 32'd0);
        reset = 1'b0;
        tick();

        // Single last word
        do_start();
        check_eq("start_ready", {31'd0, in_ready_o}, 32'd1);
        offer(32'h2401002C, 1'b1, h0);
        in_valid_i = 1'b0;
        repeat (3) tick();
        check_eq("w1_done_early", {31'd0, done_o}, 32'd0);
        check_eq("w1_hold_early", {31'd0, cpu_hold_o}, 32'd1);
        tick();
        check_eq("w1_done", {31'd0, done_o}, 32'd1);
        check_eq("w1_hold", {31'd0, cpu_hold_o}, 32'd0);
        check_eq("w1_wc",   {24'd0, word_count_o}, 32'd1);
        check_eq("w1_b0",   {24'd0, shadow[0]}, 32'h24);
        check_eq("w1_b1",   {24'd0, shadow[1]}, 32'h01);
        check_eq("w1_b2",   {24'd0, shadow[2]}, 32'h00);
        check_eq("w1_b3",   {24'd0, shadow[3]}, 32'h2C);

        // Three words held valid back to back
        words3[0] = 32'h90220000;
        words3[1] = 32'h24240024;
        words3[2] = 32'h00002821;
        do_start();
        check_eq("s3_hold", {31'd0, cpu_hold_o}, 32'd1);
        offer(words3[0], 1'b0, h0);
        offer(words3[1], 1'b0, h1);
        offer(words3[2], 1'b1, h2);
        in_valid_i = 1'b0;
        repeat (4) tick();
        check_eq("b2b_gap1", h1 - h0, 32'd5);
        check_eq("b2b_gap2", h2 - h1, 32'd5);
        check_eq("b2b_wc",   {24'd0, word_count_o}, m_wc);
        check_eq("b2b_done", {31'd0, done_o}, 32'd1);
        check_eq("b2b_b8",   {24'd0, shadow[8]}, 32'h00);
        check_eq("b2b_b11",  {24'd0, shadow[11]}, 32'h21);
        check_eq("b2b_drain", exp_q.size(), 32'd0);

        // Valid dropped between words; start pulsed mid-write is ignored
        do_start();
        offer($urandom, 1'b0, h0);
        in_valid_i = 1'b0;
        repeat (4) tick();
        for (int g = 0; g < 3; g++) begin
            check_eq("gap_we", {31'd0, mem_we_o}, 32'd0);
            check_eq("gap_ready", {31'd0, in_ready_o}, 32'd1);
            tick();
        end
        w = $urandom;
        offer(w, 1'b1, h1);
        in_valid_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        check_eq("gap_b4",   {24'd0, shadow[4]}, {24'd0, w[31:24]});
        check_eq("gap_wc",   {24'd0, word_count_o}, m_wc);
        check_eq("gap_done", {31'd0, done_o}, 32'd1);

        // Random sessions with random gaps and stray start pulses during writes
        for (int s = 0; s < 3; s++) begin
            n = $urandom_range(1, 6);
            do_start();
            for (int i = 0; i < n; i++) begin
                offer($urandom, (i == n - 1), h0);
                in_valid_i = 1'b0;
                for (int t = 0; t < 4; t++) begin
                    start_i = 1'($urandom_range(0, 1));
                    tick();
                end
                start_i = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            check_eq("rs_wc",   {24'd0, word_count_o}, m_wc);
            check_eq("rs_done", {31'd0, done_o}, 32'd1);
            check_eq("rs_hold", {31'd0, cpu_hold_o}, 32'd0);
            check_eq("rs_drain", exp_q.size(), 32'd0);
        end

        // Fill memory completely, then offer one more word
        do_start();
        for (int i = 0; i < DEPTH / 4; i++) begin
            offer($urandom, 1'b0, h0);
            in_valid_i = 1'b0;
            repeat (4) tick();
            repeat ($urandom_range(0, 1)) tick();
        end
        check_eq("full_last_addr", last_wr_addr, DEPTH - 1);
        check_eq("full_ready", {31'd0, in_ready_o}, 32'd0);
        check_eq("full_wc",    {24'd0, word_count_o}, m_wc);
        check_eq("full_ovf",   {31'd0, overflow_o}, 32'd0);
        repeat (2) begin
            tick();
            check_eq("full_hold_ready", {31'd0, in_ready_o}, 32'd0);
        end
        in_word_i  = $urandom;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check_eq("ovf_flag", {31'd0, overflow_o}, 32'd1);
        check_eq("ovf_hold", {31'd0, cpu_hold_o}, 32'd1);
        check_eq("ovf_wc",   {24'd0, word_count_o}, 32'd128);
        check_eq("ovf_we",   {31'd0, mem_we_o}, 32'd0);
        check_eq("ovf_done", {31'd0, done_o}, 32'd0);
        do_start();
        check_eq("ovf_clear", {31'd0, overflow_o}, 32'd0);
        check_eq("ovf_restart_ready", {31'd0, in_ready_o}, 32'd1);
        check_eq("ovf_restart_wc", {24'd0, word_count_o}, 32'd0);

        // Reset after the second byte write of a word
        offer(32'hAABBCCDD, 1'b0, h0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        in_valid_i = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_eq("mid_rst_we",    {31'd0, mem_we_o}, 32'd0);
        check_eq("mid_rst_wc",    {24'd0, word_count_o}, 32'd0);
        check_eq("mid_rst_hold",  {31'd0, cpu_hold_o}, 32'd1);
        check_eq("mid_rst_ready", {31'd0, in_ready_o}, 32'd0);
        check_eq("mid_rst_b0",    {24'd0, shadow[0]}, 32'hAA);
        check_eq("mid_rst_b1",    {24'd0, shadow[1]}, 32'hBB);
        reset = 1'b0;
        tick();
        check_eq("mid_rst_idle_we", {31'd0, mem_we_o}, 32'd0);
        do_start();
        offer(32'h11223344, 1'b1, h0);
        in_valid_i = 1'b0;
        repeat (4) tick();
        check_eq("rw_b0", {24'd0, shadow[0]}, 32'h11);
        check_eq("rw_b1", {24'd0, shadow[1]}, 32'h22);
        check_eq("rw_b2", {24'd0, shadow[2]}, 32'h33);
        check_eq("rw_b3", {24'd0, shadow[3]}, 32'h44);
        check_eq("rw_done", {31'd0, done_o}, 32'd1);
        check_eq("rw_wc",   {24'd0, word_count_o}, 32'd1);
        check_eq("end_drain", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
